// File: rtl/key_step_conditioner.sv
// Button/switch front end: synchronises and debounces KEY0 and SW, and emits
// one Clk-wide step pulse per clean press, plus a switch snapshot taken at that step.
module key_step_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SW_W            = 5
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            key_n,
  input  logic [SW_W-1:0] sw_raw,
  output logic            step,
  output logic            key_pressed,
  output logic [SW_W-1:0] sw_stable,
  output logic [SW_W-1:0] sw_snap,
  output logic [7:0]      step_count
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CONFIRM = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [SYNC_STAGES-1:0]           key_sync;
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync;
  logic [SW_W-1:0] sw_s;
  logic [SW_W-1:0] smp;
  logic [SW_W-1:0] agree;
  logic            ks;

  // Key chain resets to "released" so reset release never looks like a press.
  always_ff @(posedge Clk) begin
    if (reset) begin
      key_sync <= '1;
      sw_sync  <= '0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], key_n};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign ks   = key_sync[SYNC_STAGES-1];
  assign sw_s = sw_sync[SYNC_STAGES-1];

  // The IDLE sample that detects the edge counts as the first stable cycle,
  // so the wait states confirm one count early to hit the stated latency.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= ARM;
      cnt         <= '0;
      step        <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        ARM: begin
          if (!ks) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (!ks) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (ks) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CONFIRM) begin
            state       <= PRESSED;
            cnt         <= '0;
            step        <= 1'b1;
            key_pressed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (ks) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!ks) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CONFIRM) begin
            state       <= IDLE;
            cnt         <= '0;
            key_pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= ARM;
          cnt         <= '0;
          key_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign tick = (tick_cnt == LAST);

  always_ff @(posedge Clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A switch bit only moves when two consecutive tick samples agree.
  assign agree = ~(sw_s ^ smp);

  always_ff @(posedge Clk) begin
    if (reset) begin
      smp       <= '0;
      sw_stable <= '0;
    end else if (tick) begin
      smp       <= sw_s;
      sw_stable <= (sw_stable & ~agree) | (smp & agree);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sw_snap    <= '0;
      step_count <= '0;
    end else if (step) begin
      sw_snap    <= sw_stable;
      step_count <= step_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench for key_step_conditioner: each debounced press queues its
// expected step cycle, snapshot and count; a monitor pops them as steps appear.
module tb_key_step_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 4;
  localparam int unsigned W    = 5;
  localparam int unsigned LAT  = SYNC + DC;

  typedef struct {
    int unsigned cyc;
    logic [W-1:0] snap;
    logic [7:0]   cnt;
  } exp_t;

  logic         Clk;
  logic         reset;
  logic         key_n;
  logic [W-1:0] sw_raw;
  logic         step;
  logic         key_pressed;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_snap;
  logic [7:0]   step_count;

  exp_t         exp_q[$];
  exp_t         last_e;
  logic         chk_pending = 1'b0;
  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [7:0]   step_model;
  logic [W-1:0] sw_model;

  key_step_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DC),
    .SW_W(W)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .key_n(key_n),
    .sw_raw(sw_raw),
    .step(step),
    .key_pressed(key_pressed),
    .sw_stable(sw_stable),
    .sw_snap(sw_snap),
    .step_count(step_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic hold(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_expect();
    key_n = 1'b0;
    step_model = step_model + 8'd1;
    exp_q.push_back('{cyc: cyc + LAT, snap: sw_model, cnt: step_model});
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clk);
      if (chk_pending) begin
        chk_pending = 1'b0;
        n_checks++;
        if (sw_snap !== last_e.snap)
          $display("FAIL step_snap: got %b expected %b", sw_snap, last_e.snap);
        else n_pass++;
        n_checks++;
        if (step_count !== last_e.cnt)
          $display("FAIL step_count: got %0d expected %0d", step_count, last_e.cnt);
        else n_pass++;
      end
      if (step === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_step: step=1 at cycle %0d, expected 0", cyc);
        end else begin
          last_e = exp_q.pop_front();
          chk_pending = 1'b1;
          if (cyc !== last_e.cyc || key_pressed !== 1'b1)
            $display("FAIL step_timing: got cycle %0d key_pressed %b expected cycle %0d key_pressed 1",
                     cyc, key_pressed, last_e.cyc);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_n = 1'b1; sw_raw = '0;
    sw_model = '0; step_model = 8'd0;
    hold(3);
    n_checks++;
    if ({step, key_pressed, sw_stable, sw_snap, step_count} !== '0)
      $display("FAIL reset_state: got step=%b kp=%b st=%b snap=%b cnt=%0d expected all 0",
               step, key_pressed, sw_stable, sw_snap, step_count);
    else n_pass++;
    reset = 1'b0;
    hold(10);
  endtask

  task automatic test_single_press();
    press_expect();
    hold(10);
    n_checks++;
    if (key_pressed !== 1'b1) $display("FAIL press_level: got %b expected 1", key_pressed);
    else n_pass++;
    n_checks++;
    if (step_count !== 8'd1) $display("FAIL press_count: got %0d expected 1", step_count);
    else n_pass++;
    key_n = 1'b1;
    hold(10);
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL release_level: got %b expected 0", key_pressed);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL press_missing_step: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0; hold(2);
      key_n = 1'b1; hold(2);
    end
    n_checks++;
    if (step_count !== 8'd1) $display("FAIL bounce_press_count: got %0d expected 1", step_count);
    else n_pass++;
    press_expect();
    hold(12);
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b1; hold(2);
      key_n = 1'b0; hold(2);
    end
    key_n = 1'b1;
    hold(10);
    n_checks++;
    if (step_count !== 8'd2) $display("FAIL bounce_count: got %0d expected 2", step_count);
    else n_pass++;
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL bounce_release_level: got %b expected 0", key_pressed);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bounce_missing_step: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_held_through_reset();
    key_n = 1'b0; reset = 1'b1;
    hold(3);
    exp_q.delete();
    step_model = 8'd0;
    reset = 1'b0;
    hold(12);
    n_checks++;
    if (step_count !== 8'd0) $display("FAIL held_reset_count: got %0d expected 0", step_count);
    else n_pass++;
    n_checks++;
    if (key_pressed !== 1'b0) $display("FAIL held_reset_level: got %b expected 0", key_pressed);
    else n_pass++;
    key_n = 1'b1;
    hold(8);
    press_expect();
    hold(10);
    key_n = 1'b1;
    hold(10);
    n_checks++;
    if (step_count !== 8'd1) $display("FAIL held_reset_repress: got %0d expected 1", step_count);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL held_reset_missing: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_switch_debounce();
    sw_raw = 5'b10110; sw_model = 5'b10110;
    hold(12);
    n_checks++;
    if (sw_stable !== 5'b10110) $display("FAIL sw_settle: got %b expected 10110", sw_stable);
    else n_pass++;
    sw_raw = 5'b10111;
    hold(1);
    sw_raw = 5'b10110;
    for (int i = 0; i < 16; i++) begin
      hold(1);
      n_checks++;
      if (sw_stable !== 5'b10110) $display("FAIL sw_glitch: got %b expected 10110", sw_stable);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    sw_raw = 5'b00100; sw_model = 5'b00100;
    hold(12);
    n_checks++;
    if (sw_stable !== 5'b00100) $display("FAIL snap_settle: got %b expected 00100", sw_stable);
    else n_pass++;
    press_expect();
    hold(10);
    sw_raw = 5'b01000; sw_model = 5'b01000;
    hold(12);
    n_checks++;
    if (sw_snap !== 5'b00100) $display("FAIL snap_hold: got %b expected 00100", sw_snap);
    else n_pass++;
    key_n = 1'b1;
    hold(10);
    press_expect();
    hold(10);
    n_checks++;
    if (sw_snap !== 5'b01000) $display("FAIL snap_update: got %b expected 01000", sw_snap);
    else n_pass++;
    key_n = 1'b1;
    hold(10);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL snap_missing_step: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    sw_raw = '0; sw_model = '0; reset = 1'b1;
    hold(2);
    exp_q.delete();
    step_model = 8'd0;
    reset = 1'b0;
    hold(12);
    for (int i = 0; i < 256; i++) begin
      press_expect(); hold(7);
      key_n = 1'b1;   hold(7);
    end
    n_checks++;
    if (step_count !== 8'd0) $display("FAIL wrap_count: got %0d expected 0", step_count);
    else n_pass++;
    sw_raw = 5'b10001; sw_model = 5'b10001;
    hold(12);
    for (int i = 0; i < 2; i++) begin
      press_expect(); hold(7);
      key_n = 1'b1;   hold(7);
    end
    n_checks++;
    if (step_count !== 8'd2) $display("FAIL post_wrap_count: got %0d expected 2", step_count);
    else n_pass++;
    key_n = 1'b0;
    hold(4);
    reset = 1'b1;
    hold(1);
    n_checks++;
    if ({step, key_pressed, sw_stable, sw_snap, step_count} !== '0)
      $display("FAIL midpress_reset: got step=%b kp=%b st=%b snap=%b cnt=%0d expected all 0",
               step, key_pressed, sw_stable, sw_snap, step_count);
    else n_pass++;
    key_n = 1'b1;
    hold(1);
    reset = 1'b0;
    hold(12);
    n_checks++;
    if (step_count !== 8'd0) $display("FAIL midpress_no_step: got %0d expected 0", step_count);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL wrap_missing_step: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b1; sw_raw = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_held_through_reset();
    test_switch_debounce();
    test_snapshot();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
